// File: rtl/dpcm_decoder.sv
// DPCM decoder: accumulates modulo differences (or reloads on resync) into a
// predictor and buffers each reconstructed sample in a 2-entry output FIFO.
module dpcm_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] diff,
    input  logic             resync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sample,
    output logic [CNT_W-1:0] sample_count,
    output logic [1:0]       fifo_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pred_next;

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both 1; ready/valid here come from registered state only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready     = (state_q != FULL);
    assign out_valid    = (state_q != EMPTY);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign pred_next    = resync ? diff : WIDTH'(pred_q + diff);
    assign sample       = head_q;
    assign sample_count = cnt_q;
    assign fifo_state_o = state_q;

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (push) pred_d = pred_next;
        if (pop)  cnt_d  = cnt_q + CNT_W'(1);
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = pred_next;
                    state_d = ONE;
                end
            end
            ONE: begin
                // Push and pop together replace the head in place.
                if (push && pop) begin
                    head_d = pred_next;
                end else if (push) begin
                    tail_d  = pred_next;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            pred_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dpcm_decoder.sv
// Bench for dpcm_decoder: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and an encoder loopback.
module tb_dpcm_decoder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int CMASK = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff;
    logic             resync;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sample;
    logic [CNT_W-1:0] sample_count;
    logic [1:0]       fifo_state_o;

    dpcm_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .diff         (diff),
        .resync       (resync),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sample       (sample),
        .sample_count (sample_count),
        .fifo_state_o (fifo_state_o)
    );

    // clock / reset
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: predictor plus a queue of buffered samples
    int               m_pred = 0;
    int               m_cnt  = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               got_q[$];
    int               orig_q[$];
    bit               lb_active = 1'b0;
    int               lb_pops   = 0;

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_pred = 0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            bit m_ready, m_valid;
            int v;
            m_ready = (exp_q.size() < 2);
            m_valid = (exp_q.size() > 0);
            if (m_valid && out_ready) begin
                v = int'(exp_q.pop_front());
                m_cnt = (m_cnt + 1) & CMASK;
                got_q.push_back(v);
                if (lb_active) begin
                    lb_pops++;
                    if (orig_q.size() == 0) chk("lb_extra_output", 1, 0);
                    else chk("lb_stream", v, orig_q.pop_front());
                end
            end
            if (in_valid && m_ready) begin
                m_pred = resync ? int'(diff) : ((m_pred + int'(diff)) & MASK);
                exp_q.push_back(WIDTH'(m_pred));
            end
        end
    end

    // per-cycle compare away from the active edge
    initial forever begin
        @(negedge clock);
        if (reset) begin
            chk("in_ready", int'(in_ready), int'(exp_q.size() < 2));
            chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            chk("sample_count", int'(sample_count), m_cnt);
            chk("fifo_state", int'(fifo_state_o), exp_q.size());
            if (exp_q.size() > 0) chk("sample", int'(sample), int'(exp_q[0]));
        end
    end

    // driver tasks
    task automatic send(input int d, input bit rs);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        diff     = WIDTH'(d);
        resync   = rs;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            done = acc;
        end
        if (!done) chk("send_timeout", 1, 0);
        in_valid = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        got_q.delete();
    endtask

    int e1[4] = '{3, 5, 4, 5};
    int e3[3] = '{1, 2, 3};
    bit lb_done = 1'b0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        diff      = '0;
        resync    = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_count", int'(sample_count), 0);
        idle(2);
        reset = 1'b1;

        // diffs 3,2,15,1 with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 3 : (i == 1) ? 2 : (i == 2) ? 15 : 1, 1'b0);
            chk("s1_sample", int'(sample), e1[i]);
        end
        idle(1);
        chk("s1_count", int'(sample_count), 4);
        chk("s1_drained", int'(out_valid), 0);
        for (int i = 0; i < 4; i++) chk("s1_log", got_q[i], e1[i]);

        // resync to 9, then add 8 -> 1
        send(9, 1'b1);
        chk("s2_resync", int'(sample), 9);
        send(8, 1'b0);
        chk("s2_wrap", int'(sample), 1);
        idle(1);
        chk("s2_count", int'(sample_count), 6);

        // backpressure: three diffs of 1 with out_ready low
        pulse_reset();
        out_ready = 1'b0;
        send(1, 1'b0);
        send(1, 1'b0);
        chk("s3_full_ready", int'(in_ready), 0);
        in_valid = 1'b1;
        diff     = 4'd1;
        idle(3);
        chk("s3_held_sample", int'(sample), 1);
        chk("s3_held_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        idle(1);
        chk("s3_second", int'(sample), 2);
        idle(1);
        chk("s3_third", int'(sample), 3);
        in_valid = 1'b0;
        idle(1);
        chk("s3_empty", int'(out_valid), 0);
        chk("s3_log_len", got_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("s3_log", got_q[i], e3[i]);
        chk("s3_count", int'(sample_count), 3);

        // ONE holding 4, push and pop together
        out_ready = 1'b0;
        send(4, 1'b1);
        chk("s4_one", int'(fifo_state_o), 1);
        out_ready = 1'b1;
        send(2, 1'b0);
        chk("s4_sample", int'(sample), 6);
        chk("s4_state", int'(fifo_state_o), 1);
        chk("s4_count", int'(sample_count), 4);
        idle(1);

        // async reset with FIFO full and predictor 7
        out_ready = 1'b0;
        send(7, 1'b1);
        send(0, 1'b0);
        chk("s5_full", int'(fifo_state_o), 2);
        #3;
        reset = 1'b0;
        #1;
        chk("s5_out_valid", int'(out_valid), 0);
        chk("s5_in_ready", int'(in_ready), 1);
        chk("s5_count", int'(sample_count), 0);
        chk("s5_sample", int'(sample), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        send(5, 1'b0);
        chk("s5_after", int'(sample), 5);
        idle(1);

        // loopback from a modulo encoder with random stalls
        pulse_reset();
        lb_active = 1'b1;
        fork
            begin
                int prev;
                prev = 0;
                for (int i = 0; i < 200; i++) begin
                    int s;
                    s = int'($urandom_range(0, MASK));
                    orig_q.push_back(s);
                    send((s - prev) & MASK, 1'b0);
                    prev = s;
                    idle(int'($urandom_range(0, 2)));
                end
                lb_done = 1'b1;
            end
            begin
                while (!lb_done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 20 && orig_q.size() != 0; i++) idle(1);
        chk("lb_drained", orig_q.size(), 0);
        chk("lb_pops", lb_pops, 200);
        lb_active = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
